// File: rtl/apb_master_mc.sv
// apb_master_mc: multi-slave APB4 master turning valid/ready commands into SETUP/ACCESS transfers
// Ports: pclk/preset (sync, active-low); cmd_* command in, cmd_ready handshake;
// rsp_valid/rsp_rdata/rsp_err/rsp_timeout single-cycle response;
// psel/penable/pwrite/paddr/pwdata/pstrb/pprot APB request; prdata/pready/pslverr per-slave returns.
module apb_master_mc #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int NUM_SLV = 4,
  parameter  int SLV_LSB = 12,
  parameter  int TIMEOUT = 16,
  localparam int IDX_W   = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic [STRB_W-1:0]         cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [STRB_W-1:0]         pstrb,
  output logic [2:0]                pprot,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t              state_q, state_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d, sel_rdata;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
  logic [IDX_W-1:0]    idx;
  logic                rdy, serr;
  always_comb begin
    idx = cmd_addr[SLV_LSB +: IDX_W];
    // psel_q is one-hot, so masking picks only the addressed slave's handshake
    rdy = |(pready & psel_q);
    serr = |(pslverr & psel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (psel_q[i]) sel_rdata |= prdata[i*DATA_W +: DATA_W];
    state_d = state_q;
    psel_d = psel_q;
    penable_d = penable_q;
    pwrite_d = pwrite_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d = pstrb_q;
    pprot_d = pprot_q;
    cnt_d = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        if ({1'b0, idx} < (IDX_W+1)'(NUM_SLV)) begin
          state_d = SETUP;
          psel_d = NUM_SLV'(1) << idx;
          pwrite_d = cmd_write;
          paddr_d = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d = cmd_write ? cmd_strb : '0;
          pprot_d = cmd_prot;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
        cnt_d = '0;
      end
      ACCESS: if (rdy) begin
        state_d = IDLE;
        psel_d = '0;
        penable_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d = serr;
        rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
      end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT-1)) begin
        state_d = IDLE;
        psel_d = '0;
        penable_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d = 1'b1;
        rsp_timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q <= IDLE;
      psel_q <= '0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      pprot_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q <= pstrb_d;
      pprot_q <= pprot_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign cmd_ready = (state_q == IDLE) && preset;
  assign psel = psel_q;
  assign penable = penable_q;
  assign pwrite = pwrite_q;
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
  assign pstrb = pstrb_q;
  assign pprot = pprot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_mc.sv
// tb_apb_master_mc: randomized scoreboard bench for apb_master_mc (3 slaves, timeout 4)
module tb_apb_master_mc;
  localparam int NS = 3, TO = 4, DW = 32, AW = 32;
  logic pclk = 0, preset = 0;
  always #5 pclk = ~pclk;
  logic cmd_valid = 0, cmd_write = 0;
  logic cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0] cmd_strb = '0;
  logic [2:0] cmd_prot = '0;
  logic rsp_valid, rsp_err, rsp_timeout, penable, pwrite;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [NS-1:0] psel, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [3:0] pstrb;
  logic [2:0] pprot;
  logic [NS*DW-1:0] prdata = '0;
  apb_master_mc #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SLV_LSB(12), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready),
    .pslverr(pslverr));
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;
  // slave model: ready after cur_w wait states of ACCESS; unselected slaves drive junk
  int acc_cnt = 0;
  always @(posedge pclk) acc_cnt <= penable ? acc_cnt + 1 : 0;
  int cur_w = 0;
  logic cur_err = 0;
  logic [NS-1:0] junk_rdy = '0, junk_err = '0;
  assign pready = (psel & {NS{penable && acc_cnt == cur_w}}) | (~psel & junk_rdy);
  assign pslverr = (psel & {NS{cur_err}}) | (~psel & junk_err);
  typedef struct {logic [DW-1:0] rdata; logic err; logic to; int at;} rsp_t;
  rsp_t sb[$];
  rsp_t m;
  logic [NS-1:0] e_psel = '0;
  logic [AW-1:0] e_paddr = '0;
  logic [DW-1:0] e_pwdata = '0;
  logic [3:0] e_pstrb = '0;
  logic [2:0] e_pprot = '0;
  logic e_pwrite = 0;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge pclk) if (preset) begin
    if (rsp_valid) begin
      if (sb.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else begin
        m = sb.pop_front();
        chk("rsp_cycle", cyc, m.at);
        chk("rsp_rdata", rsp_rdata, m.rdata);
        chk("rsp_err", rsp_err, m.err);
        chk("rsp_timeout", rsp_timeout, m.to);
      end
    end else chk("rsp_idle_zero", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    if (psel != 0) chk("apb_fields", {psel, paddr, pwrite, pwdata, pstrb, pprot},
                       {e_psel, e_paddr, e_pwrite, e_pwdata, e_pstrb, e_pprot});
    chk("penable_wo_psel", penable & ~|psel, 0);
  end
  // reference: decode error, timeout, or normal completion after w wait states
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, input int w, input logic se,
                       input logic [NS*DW-1:0] rd);
    int guard = 0;
    int idx;
    rsp_t e;
    while (!cmd_ready && guard < 100) begin @(negedge pclk); guard++; end
    if (!cmd_ready) begin chk("cmd_ready_wait", cmd_ready, 1); return; end
    idx = int'(addr[13:12]);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr; cmd_valid = 1;
    cur_w = w; cur_err = se; prdata = rd;
    junk_rdy = NS'($urandom); junk_err = NS'($urandom);
    e.rdata = '0; e.err = 1; e.to = 0;
    if (idx >= NS) e.at = cyc + 1;
    else if (w >= TO) begin e.to = 1; e.at = cyc + 2 + TO; end
    else begin
      e.err = se; e.at = cyc + 3 + w;
      e.rdata = wr ? '0 : rd[idx*DW +: DW];
    end
    if (idx < NS) begin
      e_psel = NS'(1 << idx); e_paddr = addr; e_pwrite = wr; e_pwdata = wd;
      e_pstrb = wr ? st : 4'h0; e_pprot = pr;
    end
    sb.push_back(e);
    @(posedge pclk);
    @(negedge pclk);
  endtask
  task automatic idle(input int n);
    cmd_valid = 0;
    repeat (n) @(negedge pclk);
  endtask
  function automatic logic [NS*DW-1:0] rnd_rd();
    return {$urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic [NS*DW-1:0] rd;
    int guard;
    repeat (3) @(negedge pclk);
    chk("reset_outputs", {psel, penable, pwrite, paddr, pwdata, pstrb, pprot}, 0);
    chk("reset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    preset = 1;
    @(negedge pclk);
    chk("ready_after_reset", cmd_ready, 1);
    issue(1, 32'h0000_2010, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 0, rnd_rd());
    rd = rnd_rd(); rd[63:32] = 32'h1234_5678;
    issue(0, 32'h0000_1000, 32'h5555_0000, 4'hA, 3'd1, 2, 0, rd);
    issue(1, 32'h0000_2ABC, 32'h0BAD_F00D, 4'h3, 3'd7, 1, 1, rnd_rd());
    issue(0, 32'h0000_3000, 32'h0, 4'hF, 3'd0, 0, 0, rnd_rd());
    issue(0, 32'h0000_1004, 32'h0, 4'h0, 3'd0, 9, 0, rnd_rd());
    issue(0, 32'h0000_0008, 32'h0, 4'h0, 3'd5, 3, 0, rnd_rd());
    issue(1, 32'h0000_200C, 32'h7777_8888, 4'h5, 3'd3, 4, 0, rnd_rd());
    idle(2);
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
            $urandom_range(0, 5), 1'($urandom), rnd_rd());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    for (int i = 0; i < 3; i++) issue(0, 32'h0000_1000 + i*4, 0, 0, 0, 0, 0, rnd_rd());
    issue(1, 32'h0000_0040, 32'hCAFE_0001, 4'hF, 3'd1, 5, 0, rnd_rd());
    cmd_valid = 0;
    guard = 0;
    while (!penable && guard < 20) begin @(negedge pclk); guard++; end
    chk("access_reached", penable, 1);
    chk("sb_inflight", sb.size(), 1);
    preset = 0;
    @(posedge pclk);
    @(negedge pclk);
    chk("midreset_apb", {psel, penable, pwrite, paddr, pwdata, pstrb, pprot}, 0);
    chk("midreset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
    chk("midreset_cmd_ready", cmd_ready, 0);
    sb.delete();
    preset = 1;
    idle(8);
    issue(0, 32'h0000_2000, 0, 0, 0, 1, 0, rnd_rd());
    idle(8);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_master_mc.md
# apb_master_mc

Parametrised, multi-slave APB4 master. It converts a valid/ready command interface into APB SETUP/ACCESS transfers, decodes the target slave from address bits, and returns read data plus error status on a one-cycle response strobe. Compared with the first-generation master, it adds configurable widths and slave count, `pstrb`/`pprot`, `pslverr` capture, decode-error handling and a wait-state timeout. It sits between the system-side command source and up to `NUM_SLV` APB peripherals.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; multiple of 8
- `NUM_SLV`, 4, number of APB slaves (1..16)
- `SLV_LSB`, 12, LSB of the slave-index field in the address
- `TIMEOUT`, 16, maximum ACCESS cycles without `pready`; 0 disables the timeout
- Derived: `IDX_W` = max(1, clog2(`NUM_SLV`)); `STRB_W` = `DATA_W`/8

Ports:
- `pclk`, in, 1, clock; all logic on the rising edge
- `preset`, in, 1, synchronous active-low reset
- `cmd_valid`, in, 1, command request
- `cmd_ready`, out, 1, command accepted when high with `cmd_valid`
- `cmd_write`, in, 1, 1 = write, 0 = read
- `cmd_addr`, in, `ADDR_W`, byte address
- `cmd_wdata`, in, `DATA_W`, write data
- `cmd_strb`, in, `STRB_W`, write byte strobes
- `cmd_prot`, in, 3, protection attributes
- `rsp_valid`, out, 1, one-cycle completion strobe
- `rsp_rdata`, out, `DATA_W`, read data
- `rsp_err`, out, 1, slave error, decode error or timeout
- `rsp_timeout`, out, 1, error cause is timeout
- `psel`, out, `NUM_SLV`, one-hot slave select
- `penable`, out, 1, ACCESS phase
- `pwrite`, out, 1, transfer direction
- `paddr`, out, `ADDR_W`, transfer address
- `pwdata`, out, `DATA_W`, write data
- `pstrb`, out, `STRB_W`, write strobes
- `pprot`, out, 3, protection attributes
- `prdata`, in, `NUM_SLV`*`DATA_W`, concatenated slave read data; slave i occupies [i*`DATA_W` +: `DATA_W`]
- `pready`, in, `NUM_SLV`, per-slave ready
- `pslverr`, in, `NUM_SLV`, per-slave error

## Operation
- States: IDLE, SETUP, ACCESS. All outputs are registered except `cmd_ready`, which is 1 exactly when the state is IDLE and `preset` = 1.
- Reset (`preset` = 0 at an edge) forces state IDLE. All outputs are driven 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `pprot`, `rsp_*`.
- Slave index: idx = `cmd_addr`[`SLV_LSB` +: `IDX_W`].
- IDLE, on accept with idx < `NUM_SLV`:
  - Register `paddr`, `pwrite`, `pwdata`, `pprot` and `psel`[idx] = 1.
  - `pstrb` = `cmd_strb` for writes, 0 for reads.
  - Go to SETUP.
- IDLE, on accept with idx ≥ `NUM_SLV` (decode error):
  - No `psel` is driven and the state stays IDLE.
  - Next cycle: `rsp_valid` = 1, `rsp_err` = 1, `rsp_timeout` = 0, `rsp_rdata` = 0.
- SETUP: `penable` = 0 for one cycle, then ACCESS with `penable` = 1. `paddr`, `pwdata`, `pstrb`, `pwrite` and `pprot` stay stable from SETUP to completion.
- ACCESS, completion when `pready`[idx] = 1:
  - Drop `psel` and `penable`; go to IDLE.
  - Next cycle: `rsp_valid` = 1 and `rsp_err` = `pslverr`[idx]. `rsp_rdata` = `prdata` slice idx for reads, or 0 for writes.
- ACCESS timeout:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready`[idx] = 0.
  - When `TIMEOUT` ≠ 0 and the counter reaches `TIMEOUT`-1 with `pready` still low, abort the transfer. Drop `psel` and `penable`; go to IDLE.
  - Response: `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
- `pready` high on the same cycle as the timeout limit counts as a normal completion; the timeout is not signalled.
- `pready`/`pslverr` of unselected slaves are ignored.
- There is no response backpressure: `rsp_valid` is a single-cycle pulse. `rsp_*` fields are 0 whenever `rsp_valid` = 0.

## Timing
- Accept at edge N (IDLE) → SETUP visible in cycle N+1 → ACCESS in N+2.
- Zero wait states: `pready` sampled high at the end of N+2; `rsp_valid` in N+3, and `cmd_ready` is high again in the same cycle.
- Minimum transfer period is 3 cycles. A response may coincide with acceptance of the next command.
- With w wait states, `rsp_valid` appears in N+3+w.
- Timeout: ACCESS lasts exactly `TIMEOUT` cycles; `rsp_valid` follows one cycle later.
- Reset mid-transfer: `psel`/`penable` go low at the reset edge. No response is issued for the aborted transfer.

## Test plan
- Write, `NUM_SLV`=4, addr 0x0000_2010, data 0xDEAD_BEEF, strb 0xF, slave 2 `pready` = 1 → `psel` = 0100 for 2 cycles, `penable` in the 2nd. `rsp_valid` at N+3 with `rsp_err` = 0, `rsp_rdata` = 0.
- Read from slave 1 with 2 wait states, `prdata` slice 1 = 0x1234_5678 → `rsp_valid` at N+5, `rsp_rdata` = 0x1234_5678, `pstrb` = 0 during the transfer.
- `pslverr`[3] = 1 with `pready`[3] on a write to slave 3 → `rsp_err` = 1, `rsp_timeout` = 0.
- `NUM_SLV` = 3, addr idx = 3 → no `psel`; next cycle `rsp_valid` = 1, `rsp_err` = 1.
- `TIMEOUT` = 4, `pready` held 0 → ACCESS lasts 4 cycles, then `rsp_err` = `rsp_timeout` = 1. Repeat with `pready` = 1 on the 4th cycle → normal completion.
- Back-to-back commands with `cmd_valid` held high, then `preset` = 0 during ACCESS → transfers every 3 cycles. At the reset edge all outputs are 0 and no `rsp_valid` is issued.
